// File: rtl/reshuffle_pkg.sv
// Shared types and helpers for the PosT->output-buffer reshuffle stage.
package reshuffle_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_e;

   // Operands are already < n, so a single conditional subtract gives (step+inc) mod n.
   function automatic int step_add(input int step, input int inc, input int n);
      int sum;
      sum = step + inc;
      if (sum >= n) sum = sum - n;
      return sum;
   endfunction

endpackage

// File: rtl/reshuffle_sequencer_network.sv
// Combinational row rotation of an NxN tile: output row r takes input row (r+step) mod N.
module reshuffle_network #(
   parameter int N     = 4,
   parameter int WIDTH = 32
) (
   input  logic [$clog2(N)-1:0]               step,
   input  logic [0:N-1][0:N-1][WIDTH-1:0]     in_patch,
   output logic [0:N-1][0:N-1][WIDTH-1:0]     out_patch
);

   localparam int SW = $clog2(N);
   localparam logic [SW:0] N_C = N[SW:0];

   for (genvar r = 0; r < N; r++) begin : g_row
      logic [SW:0] sum;
      logic [SW:0] src;
      assign sum = (SW+1)'(r) + {1'b0, step};
      assign src = (sum >= N_C) ? (sum - N_C) : sum;
      assign out_patch[r] = in_patch[src[SW-1:0]];
   end

endmodule

// File: rtl/reshuffle_sequencer.sv
// Frame controller: accepts PosT tiles, rotates each by a position-derived step and
// presents the result through a single registered output stage.
module reshuffle_sequencer
   import reshuffle_pkg::*;
#(
   parameter int N     = 4,
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               abort,
   input  logic [CNT_W-1:0]                   cfg_tiles_row,
   input  logic [CNT_W-1:0]                   cfg_tile_rows,
   // Config steps carry one extra bit so out-of-range values reach the range check.
   input  logic [$clog2(N):0]                 cfg_step_init,
   input  logic [$clog2(N):0]                 cfg_step_inc,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [0:N-1][0:N-1][WIDTH-1:0]     in_patch,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [0:N-1][0:N-1][WIDTH-1:0]     out_patch,
   output logic [$clog2(N)-1:0]               out_step,
   output logic                               out_row_end,
   output logic                               out_last,
   output logic                               busy,
   output logic                               done,
   output logic                               cfg_err
);

   localparam int SW = $clog2(N);
   localparam logic [SW:0] N_C = N[SW:0];

   state_e                           state_q, state_d;
   logic [CNT_W-1:0]                 tilesRow_q, tilesRow_d;
   logic [CNT_W-1:0]                 tileRows_q, tileRows_d;
   logic [CNT_W-1:0]                 col_q, col_d;
   logic [CNT_W-1:0]                 row_q, row_d;
   logic [SW-1:0]                    init_q, init_d;
   logic [SW-1:0]                    inc_q, inc_d;
   logic [SW-1:0]                    step_q, step_d;
   logic                             outValid_q, outValid_d;
   logic [0:N-1][0:N-1][WIDTH-1:0]   outPatch_q, outPatch_d;
   logic [SW-1:0]                    outStep_q, outStep_d;
   logic                             outRowEnd_q, outRowEnd_d;
   logic                             outLast_q, outLast_d;
   logic                             cfgErr_q, cfgErr_d;

   logic [0:N-1][0:N-1][WIDTH-1:0]   permPatch;
   logic                             accept;
   logic                             cfgBad;
   logic                             rowEnd;
   logic                             frameEnd;
   logic [SW-1:0]                    stepNext;

   reshuffle_network #(
      .N     (N),
      .WIDTH (WIDTH)
   ) u_net (
      .step      (step_q),
      .in_patch  (in_patch),
      .out_patch (permPatch)
   );

   assign cfgBad   = (cfg_step_init >= N_C) || (cfg_step_inc >= N_C);
   assign in_ready = (state_q == RUN) && (!outValid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign rowEnd   = (col_q == tilesRow_q - CNT_W'(1));
   assign frameEnd = rowEnd && (row_q == tileRows_q - CNT_W'(1));
   assign stepNext = SW'(step_add(int'(step_q), int'(inc_q), N));

   always_comb begin
      state_d     = state_q;
      tilesRow_d  = tilesRow_q;
      tileRows_d  = tileRows_q;
      col_d       = col_q;
      row_d       = row_q;
      init_d      = init_q;
      inc_d       = inc_q;
      step_d      = step_q;
      outValid_d  = outValid_q;
      outPatch_d  = outPatch_q;
      outStep_d   = outStep_q;
      outRowEnd_d = outRowEnd_q;
      outLast_d   = outLast_q;
      cfgErr_d    = cfgErr_q;

      if (abort) begin
         state_d    = IDLE;
         col_d      = '0;
         row_d      = '0;
         step_d     = '0;
         outValid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (cfgBad) begin
                     cfgErr_d = 1'b1;
                  end else begin
                     cfgErr_d   = 1'b0;
                     tilesRow_d = cfg_tiles_row;
                     tileRows_d = cfg_tile_rows;
                     init_d     = cfg_step_init[SW-1:0];
                     inc_d      = cfg_step_inc[SW-1:0];
                     step_d     = cfg_step_init[SW-1:0];
                     col_d      = '0;
                     row_d      = '0;
                     state_d    = ((cfg_tiles_row == '0) || (cfg_tile_rows == '0)) ? DONE : RUN;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  if (rowEnd) begin
                     col_d  = '0;
                     step_d = init_q;
                     if (frameEnd) state_d = DRAIN;
                     else          row_d   = row_q + CNT_W'(1);
                  end else begin
                     col_d  = col_q + CNT_W'(1);
                     step_d = stepNext;
                  end
               end
            end
            DRAIN: begin
               if (outValid_q && out_ready) state_d = DONE;
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // A new accept refills the stage in the same cycle the old tile leaves.
         if (accept) begin
            outValid_d  = 1'b1;
            outPatch_d  = permPatch;
            outStep_d   = step_q;
            outRowEnd_d = rowEnd;
            outLast_d   = frameEnd;
         end else if (out_ready) begin
            outValid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tilesRow_q  <= '0;
         tileRows_q  <= '0;
         col_q       <= '0;
         row_q       <= '0;
         init_q      <= '0;
         inc_q       <= '0;
         step_q      <= '0;
         outValid_q  <= 1'b0;
         outPatch_q  <= '0;
         outStep_q   <= '0;
         outRowEnd_q <= 1'b0;
         outLast_q   <= 1'b0;
         cfgErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tilesRow_q  <= tilesRow_d;
         tileRows_q  <= tileRows_d;
         col_q       <= col_d;
         row_q       <= row_d;
         init_q      <= init_d;
         inc_q       <= inc_d;
         step_q      <= step_d;
         outValid_q  <= outValid_d;
         outPatch_q  <= outPatch_d;
         outStep_q   <= outStep_d;
         outRowEnd_q <= outRowEnd_d;
         outLast_q   <= outLast_d;
         cfgErr_q    <= cfgErr_d;
      end
   end

   assign out_valid   = outValid_q;
   assign out_patch   = outPatch_q;
   assign out_step    = outStep_q;
   assign out_row_end = outRowEnd_q;
   assign out_last    = outLast_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign cfg_err     = cfgErr_q;

endmodule

// File: tb/tb_reshuffle_sequencer.sv
// Scoreboard bench for reshuffle_sequencer (N=4, WIDTH=32).
module tb_reshuffle_sequencer;

   localparam int N = 4;
   localparam int W = 32;

   typedef logic [0:N-1][0:N-1][W-1:0] patch_t;
   typedef struct packed {
      patch_t     patch;
      logic [1:0] step;
      logic       rowEnd;
      logic       last;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] cfg_tiles_row;
   logic [15:0] cfg_tile_rows;
   logic [2:0]  cfg_step_init;
   logic [2:0]  cfg_step_inc;
   logic        in_valid;
   logic        in_ready;
   patch_t      in_patch;
   logic        out_valid;
   logic        out_ready;
   patch_t      out_patch;
   logic [1:0]  out_step;
   logic        out_row_end;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        cfg_err;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t sbQ[$];

   int mTr, mRows, mInit, mInc, mStep, mCol, mRow;

   reshuffle_sequencer #(.N(N), .WIDTH(W), .CNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .cfg_tiles_row (cfg_tiles_row),
      .cfg_tile_rows (cfg_tile_rows),
      .cfg_step_init (cfg_step_init),
      .cfg_step_inc  (cfg_step_inc),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_patch      (in_patch),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_patch     (out_patch),
      .out_step      (out_step),
      .out_row_end   (out_row_end),
      .out_last      (out_last),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic patch_t rand_patch();
      patch_t p;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            p[r][c] = $urandom;
      return p;
   endfunction

   function automatic patch_t rotate(input patch_t p, input int s);
      patch_t q;
      for (int r = 0; r < N; r++) q[r] = p[(r + s) % N];
      return q;
   endfunction

   task automatic model_accept(input patch_t p);
      exp_t e;
      e.patch  = rotate(p, mStep);
      e.step   = 2'(mStep);
      e.rowEnd = (mCol == mTr - 1);
      e.last   = e.rowEnd && (mRow == mRows - 1);
      sbQ.push_back(e);
      if (e.rowEnd) begin
         mCol  = 0;
         mRow  = mRow + 1;
         mStep = mInit;
      end else begin
         mCol  = mCol + 1;
         mStep = (mStep + mInc) % N;
      end
   endtask

   task automatic pulse_start(input int tr, input int rows, input int init, input int inc);
      repeat (3) @(negedge clk);
      cfg_tiles_row = 16'(tr);
      cfg_tile_rows = 16'(rows);
      cfg_step_init = 3'(init);
      cfg_step_inc  = 3'(inc);
      start         = 1'b1;
      @(negedge clk);
      start         = 1'b0;
      cfg_tiles_row = 16'($urandom);
      cfg_tile_rows = 16'($urandom);
      cfg_step_init = 3'($urandom);
      cfg_step_inc  = 3'($urandom);
      mTr = tr; mRows = rows; mInit = init; mInc = inc;
      mStep = init; mCol = 0; mRow = 0;
      sbQ.delete();
   endtask

   task automatic drive_cycle(input logic v, input patch_t p, input logic ordy,
                              output logic acc, output logic hs);
      @(negedge clk);
      in_valid  = v;
      in_patch  = p;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_patch = '0; cfg_tiles_row = '0; cfg_tile_rows = '0; cfg_step_init = '0; cfg_step_inc = '0;
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if ({out_valid, out_patch, out_step, out_row_end, out_last, busy, done, cfg_err, in_ready} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_values: got valid=%b busy=%b done=%b err=%b rdy=%b, want all 0",
                  out_valid, busy, done, cfg_err, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      compared++;
      if ({out_valid, busy, done, cfg_err, in_ready} !== 5'b0) begin
         mismatched++;
         $display("[TB] FAIL idle_after_reset: got %b want 00000", {out_valid, busy, done, cfg_err, in_ready});
      end
   endtask

   task automatic test_basic_stream();
      int sent = 0, got = 0, cyc = 0;
      logic acc, hs;
      patch_t p;
      exp_t e;
      int expStep[6] = '{1, 2, 3, 1, 2, 3};
      $display("[TB] test_basic_stream");
      pulse_start(3, 2, 1, 1);
      while (got < 6 && cyc < 60) begin
         p = rand_patch();
         drive_cycle(sent < 6, p, 1'b1, acc, hs);
         if (acc) begin model_accept(p); sent++; end
         if (hs) begin
            compared++;
            if (sbQ.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL basic_unexpected_tile: got tile %0d want none", got);
            end else begin
               e = sbQ.pop_front();
               if ({out_patch, out_step, out_row_end, out_last} !== e) begin
                  mismatched++;
                  $display("[TB] FAIL basic_tile%0d: got %h want %h", got,
                           {out_patch, out_step, out_row_end, out_last}, e);
               end
            end
            compared++;
            if (out_step !== 2'(expStep[got]) || out_row_end !== (got == 2 || got == 5) || out_last !== (got == 5)) begin
               mismatched++;
               $display("[TB] FAIL basic_flags%0d: got step=%0d re=%b last=%b want step=%0d re=%b last=%b",
                        got, out_step, out_row_end, out_last, expStep[got], (got == 2 || got == 5), (got == 5));
            end
            got++;
         end
         @(posedge clk);
         cyc++;
      end
      compared++;
      if (got != 6) begin
         mismatched++;
         $display("[TB] FAIL basic_count: got %0d tiles want 6", got);
      end
      #1;
      compared++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL basic_done_pulse: got done=%b busy=%b want 1 1", done, busy);
      end
      @(posedge clk);
      #1;
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL basic_done_end: got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_step_wrap();
      int sent = 0, got = 0, cyc = 0;
      logic acc, hs;
      patch_t p;
      exp_t e;
      int expStep[4] = '{3, 1, 3, 1};
      $display("[TB] test_step_wrap");
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            p[r][c] = W'(r);
      pulse_start(4, 1, 3, 2);
      while (got < 4 && cyc < 40) begin
         drive_cycle(sent < 4, p, 1'b1, acc, hs);
         if (acc) begin model_accept(p); sent++; end
         if (hs) begin
            e = sbQ.pop_front();
            compared++;
            if ({out_patch, out_step, out_row_end, out_last} !== e || out_step !== 2'(expStep[got])) begin
               mismatched++;
               $display("[TB] FAIL wrap_tile%0d: got step=%0d want %0d, data %h want %h", got,
                        out_step, expStep[got], out_patch, e.patch);
            end
            if (got == 0) begin
               compared++;
               if (out_patch[0][0] !== 32'd3 || out_patch[0][N-1] !== 32'd3 || out_patch[1][0] !== 32'd0) begin
                  mismatched++;
                  $display("[TB] FAIL wrap_rows: got row0=%0d row1=%0d want 3 0", out_patch[0][0], out_patch[1][0]);
               end
            end
            got++;
         end
         @(posedge clk);
         cyc++;
      end
      compared++;
      if (got != 4) begin
         mismatched++;
         $display("[TB] FAIL wrap_count: got %0d want 4", got);
      end
   endtask

   task automatic test_stall();
      int sent = 0, got = 0, cyc = 0, stallChecks = 0;
      logic acc, hs, ordy, haveSnap;
      patch_t p;
      exp_t e, snap;
      $display("[TB] test_stall");
      haveSnap = 1'b0;
      snap = '0;
      pulse_start(3, 2, 0, 1);
      while (got < 6 && cyc < 80) begin
         p = rand_patch();
         ordy = !(cyc >= 3 && cyc < 8);
         drive_cycle(sent < 6, p, ordy, acc, hs);
         if (!ordy && out_valid) begin
            compared++;
            if (in_ready !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL stall_in_ready: got %b want 0 at cycle %0d", in_ready, cyc);
            end
            if (!haveSnap) begin
               snap = {out_patch, out_step, out_row_end, out_last};
               haveSnap = 1'b1;
            end else begin
               stallChecks++;
               compared++;
               if ({out_patch, out_step, out_row_end, out_last} !== snap) begin
                  mismatched++;
                  $display("[TB] FAIL stall_hold: got %h want %h", {out_patch, out_step, out_row_end, out_last}, snap);
               end
            end
         end
         if (acc) begin model_accept(p); sent++; end
         if (hs) begin
            e = sbQ.pop_front();
            compared++;
            if ({out_patch, out_step, out_row_end, out_last} !== e) begin
               mismatched++;
               $display("[TB] FAIL stall_tile%0d: got %h want %h", got, {out_patch, out_step, out_row_end, out_last}, e);
            end
            got++;
         end
         @(posedge clk);
         cyc++;
      end
      compared++;
      if (got != 6 || sbQ.size() != 0 || stallChecks < 4) begin
         mismatched++;
         $display("[TB] FAIL stall_count: got %0d tiles, %0d left, %0d holds want 6 0 >=4",
                  got, sbQ.size(), stallChecks);
      end
   endtask

   task automatic test_empty_and_cfg_err();
      int doneCnt = 0;
      $display("[TB] test_empty_and_cfg_err");
      pulse_start(3, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         compared++;
         if (in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL empty_in_ready: got %b want 0", in_ready);
         end
         if (done === 1'b1) doneCnt++;
         @(negedge clk);
      end
      compared++;
      if (doneCnt != 1 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL empty_done: got %0d pulses busy=%b want 1 pulse busy=0", doneCnt, busy);
      end
      pulse_start(2, 2, 1, 4);
      compared++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL cfg_err_set: got err=%b busy=%b want 1 0", cfg_err, busy);
      end
   endtask

   task automatic test_abort();
      int sent = 0, got = 0, cyc = 0;
      logic acc, hs, doneSeen;
      patch_t p;
      exp_t e;
      $display("[TB] test_abort");
      pulse_start(3, 2, 2, 1);
      compared++;
      if (cfg_err !== 1'b0 || busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL abort_start: got err=%b busy=%b want 0 1", cfg_err, busy);
      end
      while (sent < 2 && cyc < 20) begin
         p = rand_patch();
         drive_cycle(1'b1, p, 1'b1, acc, hs);
         if (acc) begin model_accept(p); sent++; end
         if (hs) void'(sbQ.pop_front());
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      abort = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_clear: got valid=%b busy=%b want 0 0", out_valid, busy);
      end
      @(negedge clk);
      abort = 1'b0;
      doneSeen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen = 1'b1;
      end
      compared++;
      if (doneSeen !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_no_done: got done pulse want none");
      end

      sent = 0; cyc = 0;
      pulse_start(3, 2, 0, 2);
      while (got < 6 && cyc < 60) begin
         p = rand_patch();
         drive_cycle(sent < 6, p, ($urandom_range(0, 3) != 0), acc, hs);
         if (acc) begin model_accept(p); sent++; end
         if (hs) begin
            e = sbQ.pop_front();
            compared++;
            if ({out_patch, out_step, out_row_end, out_last} !== e) begin
               mismatched++;
               $display("[TB] FAIL abort_rerun_tile%0d: got %h want %h", got, {out_patch, out_step, out_row_end, out_last}, e);
            end
            got++;
         end
         @(posedge clk);
         cyc++;
      end
      #1;
      compared++;
      if (got != 6 || done !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL abort_rerun_end: got %0d tiles done=%b want 6 1", got, done);
      end
   endtask

   task automatic test_reset_in_drain();
      logic acc, hs, doneSeen, busySeen;
      patch_t p;
      $display("[TB] test_reset_in_drain");
      pulse_start(2, 1, 0, 1);
      p = rand_patch();
      drive_cycle(1'b1, p, 1'b1, acc, hs);
      @(posedge clk);
      p = rand_patch();
      drive_cycle(1'b1, p, 1'b1, acc, hs);
      @(posedge clk);
      drive_cycle(1'b0, p, 1'b0, acc, hs);
      compared++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || out_last !== 1'b1 || in_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL drain_state: got busy=%b valid=%b last=%b rdy=%b want 1 1 1 0",
                  busy, out_valid, out_last, in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      compared++;
      if ({out_valid, out_patch, out_step, out_row_end, out_last, busy, done, cfg_err, in_ready} !== '0) begin
         mismatched++;
         $display("[TB] FAIL async_reset: got valid=%b busy=%b done=%b last=%b want all 0",
                  out_valid, busy, done, out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 1'b0;
      busySeen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b0, p, 1'b1, acc, hs);
         if (done === 1'b1) doneSeen = 1'b1;
         if (busy === 1'b1) busySeen = 1'b1;
      end
      compared++;
      if (doneSeen !== 1'b0 || busySeen !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL after_reset: got done=%b busy=%b want 0 0", doneSeen, busySeen);
      end
   endtask

   initial begin
      test_reset();
      test_basic_stream();
      test_step_wrap();
      test_stall();
      test_empty_and_cfg_err();
      test_abort();
      test_reset_in_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
